i2c_byte_ctrl: RTL and testbench

Byte-level I2C master sequencer. It accepts START / WRITE / READ / STOP commands and drives the open-drain SCL/SDA enables.
- Timing comes from a one-clk `tick` pulse supplied by the clock divider at 4x the SCL rate.
- Sits between the register/host interface and the pads.
- Supports slave clock stretching and multi-master arbitration-loss detection.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_sync.sv | 23 ++
 rtl/i2c_byte_ctrl.sv | 177 +++++++++++++++++
 tb/tb_i2c_byte_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: command codes, FSM encodings and slot constants shared by the I2C byte controller
package i2c_pkg;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_STOP  = 2'd3;

    localparam logic [3:0] ACK_SLOT = 4'd8;

    typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;
    typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

    function automatic phase_t next_phase(input phase_t p);
        return phase_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/i2c_sync.sv
// i2c_sync: multi-flop synchronizer for the SCL/SDA pad levels, resetting to the idle-high bus level
module i2c_sync
    import i2c_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] d_i,
    output logic [1:0] q_o
);

    logic [2*STAGES-1:0] ff_q;

    // Shift both pad levels through STAGES flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff_q <= '1;
        else      ff_q <= {ff_q[2*STAGES-3:0], d_i};
    end

    assign q_o = ff_q[2*STAGES-1 -: 2];

endmodule

// File: rtl/i2c_byte_ctrl.sv
// i2c_byte_ctrl: byte-level I2C master sequencer driving open-drain SCL/SDA enables on tick phases
module i2c_byte_ctrl
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_data,
    input  logic       mack,
    output logic [7:0] rx_data,
    output logic       rx_ack,
    output logic       done,
    output logic       arb_lost,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rxsh_q, rxsh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_ack_q, rx_ack_d;
    logic       mack_q, mack_d;
    logic       rd_q, rd_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;
    logic       done_q, done_d;
    logic       arb_q, arb_d;
    logic [1:0] line_s;
    logic       scl_s, sda_s;
    logic       ack_slot;

    i2c_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i ({scl_in, sda_in}),
        .q_o (line_s)
    );

    assign scl_s    = line_s[1];
    assign sda_s    = line_s[0];
    assign ack_slot = (bit_q == ACK_SLOT);

    // Next state and line drive; the phase (the step the next tick executes) only advances on tick
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rxsh_d    = rxsh_q;
        rx_data_d = rx_data_q;
        rx_ack_d  = rx_ack_q;
        mack_d    = mack_q;
        rd_d      = rd_q;
        scl_d     = scl_q;
        sda_d     = sda_q;
        done_d    = 1'b0;
        arb_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd == CMD_START) ? START : (cmd == CMD_STOP) ? STOP : BIT;
                    phase_d = P0;
                    bit_d   = 4'd0;
                    shift_d = tx_data;
                    mack_d  = mack;
                    rd_d    = (cmd == CMD_READ);
                end
            end
            START, STOP: begin
                if (tick) begin
                    scl_d   = (state_q == START) ? (phase_q == P3) : (phase_q == P0);
                    sda_d   = (state_q == START) ? (phase_q == P2 || phase_q == P3) : (phase_q != P3);
                    phase_d = next_phase(phase_q);
                    if (phase_q == P3) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            BIT: begin
                if (tick) begin
                    case (phase_q)
                        P0: begin
                            scl_d   = 1'b1;
                            sda_d   = ack_slot ? (rd_q & mack_q) : (~rd_q & ~shift_q[7]);
                            phase_d = P1;
                        end
                        P1: begin
                            scl_d   = 1'b0;
                            phase_d = P2;
                        end
                        P2: begin
                            // A slave stretching SCL keeps us waiting here with SCL released
                            if (scl_s) begin
                                phase_d  = P3;
                                rxsh_d   = (rd_q && !ack_slot) ? {rxsh_q[6:0], sda_s} : rxsh_q;
                                rx_ack_d = (!rd_q && ack_slot) ? sda_s : rx_ack_q;
                                if (!rd_q && !ack_slot && !sda_q && !sda_s) begin
                                    state_d = IDLE;
                                    scl_d   = 1'b0;
                                    sda_d   = 1'b0;
                                    done_d  = 1'b1;
                                    arb_d   = 1'b1;
                                end
                            end
                        end
                        P3: begin
                            scl_d     = 1'b1;
                            phase_d   = P0;
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_d     = bit_q + 4'd1;
                            rx_data_d = (rd_q && bit_q == 4'd7) ? rxsh_q : rx_data_q;
                            if (ack_slot) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    // Registers; reset releases both lines immediately and drops any command in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            phase_q   <= P0;
            bit_q     <= 4'd0;
            shift_q   <= 8'h00;
            rxsh_q    <= 8'h00;
            rx_data_q <= 8'h00;
            rx_ack_q  <= 1'b1;
            mack_q    <= 1'b0;
            rd_q      <= 1'b0;
            scl_q     <= 1'b0;
            sda_q     <= 1'b0;
            done_q    <= 1'b0;
            arb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rxsh_q    <= rxsh_d;
            rx_data_q <= rx_data_d;
            rx_ack_q  <= rx_ack_d;
            mack_q    <= mack_d;
            rd_q      <= rd_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            done_q    <= done_d;
            arb_q     <= arb_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign arb_lost  = arb_q;
    assign rx_data   = rx_data_q;
    assign rx_ack    = rx_ack_q;
    assign scl_oe    = scl_q;
    assign sda_oe    = sda_q;

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// tb_i2c_byte_ctrl: directed bench for the I2C byte controller with pull-up and slave models
module tb_i2c_byte_ctrl;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       mack;
    logic [7:0] rx_data;
    logic       rx_ack;
    logic       done;
    logic       arb_lost;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;

    logic       scl_hold;
    logic       sda_slave;
    logic [7:0] seen;
    logic       ack_seen;
    logic       seen_done;
    int         tick_total = 0;
    int         t0 = 0;
    int         checks = 0;
    int         errors = 0;

    assign scl_in = ~scl_oe & ~scl_hold;
    assign sda_in = ~sda_oe & ~sda_slave;

    i2c_byte_ctrl #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .tx_data   (tx_data),
        .mack      (mack),
        .rx_data   (rx_data),
        .rx_ack    (rx_ack),
        .done      (done),
        .arb_lost  (arb_lost),
        .busy      (busy),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_in    (scl_in),
        .sda_in    (sda_in)
    );

    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    always @(posedge clk) if (tick) tick_total <= tick_total + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic m);
        @(negedge clk);
        cmd = c;
        tx_data = d;
        mack = m;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        t0 = tick_total;
    endtask

    task automatic wait_bus(input bit use_sda, input logic level, input string tag);
        int n = 0;
        while (((use_sda ? sda_in : scl_in) !== level) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, use_sda ? sda_in : scl_in, level);
    endtask

    task automatic wait_done(input int exp_ticks, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_ticks"}, tick_total - t0, exp_ticks);
    endtask

    task automatic xfer(input logic rd, input logic [7:0] d, input logic m, input logic sack,
                        input int stretch_slot, input int arb_slot, input int exp_ticks, input string tag);
        issue(rd ? CMD_READ : CMD_WRITE, d, m);
        seen = 8'h00;
        ack_seen = 1'bx;
        for (int i = 0; i < 9; i++) begin
            if (rd) sda_slave = (i < 8) ? ~d[7-i] : 1'b0;
            else    sda_slave = (i == 8) ? sack : (i == arb_slot);
            if (i == stretch_slot) begin
                int n = 0;
                while (scl_oe && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                chk({tag, "_stretch_release"}, scl_oe, 0);
                scl_hold = 1'b1;
                repeat (40) @(negedge clk);
                chk({tag, "_stretch_wait"}, scl_oe, 0);
                scl_hold = 1'b0;
            end
            wait_bus(0, 1'b1, {tag, "_scl_rise"});
            if (i < 8) seen = {seen[6:0], sda_in};
            else ack_seen = sda_in;
            if (i == arb_slot || i == 8) break;
            wait_bus(0, 1'b0, {tag, "_scl_fall"});
        end
        wait_done(exp_ticks, tag);
        sda_slave = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd = CMD_START;
        tx_data = 8'h00;
        mack = 1'b0;
        scl_hold = 1'b0;
        sda_slave = 1'b0;
        seen_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_arb", arb_lost, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_ack", rx_ack, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);

        issue(CMD_START, 8'h00, 1'b0);
        chk("start_busy", busy, 1);
        wait_bus(1, 1'b0, "start_sda_fall");
        chk("start_scl_high", scl_in, 1);
        wait_done(4, "start");
        chk("start_scl_oe", scl_oe, 1);
        chk("start_sda_oe", sda_oe, 1);

        issue(CMD_STOP, 8'h00, 1'b0);
        @(negedge clk);
        cmd = CMD_START;
        cmd_valid = 1'b1;
        chk("busy_not_ready", cmd_ready, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_bus(0, 1'b1, "stop_scl_rise");
        chk("stop_sda_low", sda_in, 0);
        wait_done(4, "stop");
        chk("stop_scl_oe", scl_oe, 0);
        chk("stop_sda_oe", sda_oe, 0);
        chk("stop_sda_bus", sda_in, 1);
        @(negedge clk);
        chk("no_queued_cmd", busy, 0);

        issue(CMD_START, 8'h00, 1'b0);
        wait_done(4, "start2");
        xfer(1'b0, 8'hA5, 1'b0, 1'b1, -1, -1, 36, "wr_a5");
        chk("wr_a5_bits", seen, 8'hA5);
        chk("wr_a5_ack_bus", ack_seen, 0);
        chk("wr_a5_rx_ack", rx_ack, 0);
        chk("wr_a5_arb", arb_lost, 0);
        chk("wr_a5_scl_low", scl_oe, 1);

        xfer(1'b1, 8'h3C, 1'b0, 1'b0, -1, -1, 36, "rd_3c");
        chk("rd_3c_bus", seen, 8'h3C);
        chk("rd_3c_nack_bus", ack_seen, 1);
        chk("rd_3c_sda_oe", sda_oe, 0);
        chk("rd_3c_rx_data", rx_data, 8'h3C);
        chk("rd_3c_rx_ack_kept", rx_ack, 0);

        xfer(1'b0, 8'h55, 1'b0, 1'b0, 3, -1, 46, "wr_55");
        chk("wr_55_bits", seen, 8'h55);
        chk("wr_55_rx_ack", rx_ack, 1);

        xfer(1'b0, 8'hFF, 1'b0, 1'b0, -1, 2, 11, "arb");
        chk("arb_lost_pulse", arb_lost, 1);
        chk("arb_scl_oe", scl_oe, 0);
        chk("arb_sda_oe", sda_oe, 0);
        chk("arb_rx_ack_kept", rx_ack, 1);
        chk("arb_ready", cmd_ready, 1);
        @(negedge clk);
        chk("arb_done_one_clk", done, 0);
        chk("arb_lost_one_clk", arb_lost, 0);
        chk("arb_ready_next", cmd_ready, 1);

        issue(CMD_START, 8'h00, 1'b0);
        wait_done(4, "start3");
        issue(CMD_READ, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_bus(0, 1'b1, "rdrst_scl_rise");
            wait_bus(0, 1'b0, "rdrst_scl_fall");
        end
        repeat (2) @(negedge clk);
        chk("pre_rst_scl_oe", scl_oe, 1);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("async_rst_scl_oe", scl_oe, 0);
        chk("async_rst_sda_oe", sda_oe, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rx_data", rx_data, 8'h00);
        seen_done = done;
        repeat (6) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        chk("rst_no_done", seen_done, 0);
        chk("rst_ready", cmd_ready, 1);
        issue(CMD_START, 8'h00, 1'b0);
        wait_done(4, "start_after_rst");
        chk("start_after_rst_scl", scl_oe, 1);
        chk("start_after_rst_sda", sda_oe, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
